// File: rtl/leitor_teclado.sv
// 4x4 active-low key-matrix scanner with frame debounce; optional auto-repeat under LEITOR_REPETE_EN.
// Latency: Valida rises 1 cycle after the DEB-th matching frame close; frame = 4*DIV cycles.
// Backpressure: valid/ack handshake; an event arriving while Valida is pending and un-acked is dropped and sets sticky Estouro.
module leitor_teclado #(
    parameter int DIV = 1000,
    parameter int DEB = 3,
    parameter int REP = 32
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] Lin,
    output logic [3:0] Col,
    output logic [3:0] Tecla,
    output logic       Valida,
    input  logic       Ack,
    output logic       Estouro
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONF, HELD, REL} estado_t;

    logic [PW-1:0] presc;
    logic [1:0]    col_idx;
    logic [3:0]    sync1, sync2;
    logic [1:0]    acc_n;
    logic [3:0]    acc_code;
    logic          tick, fecha;

    logic [3:0] rows_low;
    logic [2:0] n_col, n_sum;
    logic [1:0] row_enc, frame_n;
    logic [3:0] frame_code;
    logic       f_none, f_single, hit, conf_done, rep_fire;

    estado_t    st, st_nxt;
    logic [3:0] cnt, cnt_nxt, cand, cand_nxt;
    logic       evt;
    logic [3:0] evt_code;

    assign tick  = (presc == PW'(DIV - 1));
    assign fecha = tick && (col_idx == 2'd3);
    assign Col   = ~(4'b0001 << col_idx);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            presc    <= '0;
            col_idx  <= '0;
            sync1    <= 4'hF;
            sync2    <= 4'hF;
            acc_n    <= '0;
            acc_code <= '0;
        end else begin
            sync1 <= Lin;
            sync2 <= sync1;
            if (tick) begin
                presc   <= '0;
                col_idx <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    acc_n    <= '0;
                    acc_code <= '0;
                end else begin
                    acc_n    <= frame_n;
                    acc_code <= frame_code;
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Frame classification: low-row count saturates at 2 (anything >1 is MULTI).
    always_comb begin
        rows_low = ~sync2;
        n_col    = 3'(rows_low[0]) + 3'(rows_low[1]) + 3'(rows_low[2]) + 3'(rows_low[3]);
        row_enc  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (rows_low[r]) row_enc = 2'(r);
        end
        n_sum      = {1'b0, acc_n} + n_col;
        frame_n    = (n_sum >= 3'd2) ? 2'd2 : n_sum[1:0];
        frame_code = (n_col == 3'd1) ? {col_idx, row_enc} : acc_code;
    end

    assign f_none    = (frame_n == 2'd0);
    assign f_single  = (frame_n == 2'd1);
    assign hit       = f_single && (frame_code == cand);
    assign conf_done = ((cnt + 4'd1) == 4'(DEB));

`ifdef LEITOR_REPETE_EN
    localparam int RW = $clog2(REP + 1);
    logic [RW-1:0] rep_cnt;

    assign rep_fire = (st == HELD) && hit && (({1'b0, rep_cnt} + (RW+1)'(1)) == (RW+1)'(REP));

    // Cleared on any non-matching frame and whenever not already in HELD.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rep_cnt <= '0;
        end else if (fecha) begin
            if ((st == HELD) && hit)
                rep_cnt <= rep_fire ? '0 : rep_cnt + RW'(1);
            else
                rep_cnt <= '0;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            st   <= IDLE;
            cnt  <= '0;
            cand <= '0;
        end else begin
            st   <= st_nxt;
            cnt  <= cnt_nxt;
            cand <= cand_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        cnt_nxt  = cnt;
        cand_nxt = cand;
        if (fecha) begin
            case (st)
                IDLE: begin
                    if (f_single) begin
                        cand_nxt = frame_code;
                        cnt_nxt  = 4'd1;
                        st_nxt   = (DEB == 1) ? HELD : CONF;
                    end
                end
                CONF: begin
                    if (hit) begin
                        cnt_nxt = cnt + 4'd1;
                        if (conf_done) st_nxt = HELD;
                    end else if (f_single) begin
                        cand_nxt = frame_code;
                        cnt_nxt  = 4'd1;
                    end else begin
                        st_nxt = IDLE;
                    end
                end
                HELD: begin
                    if (f_none) begin
                        cnt_nxt = 4'd1;
                        st_nxt  = (DEB == 1) ? IDLE : REL;
                    end
                end
                REL: begin
                    if (f_none) begin
                        cnt_nxt = cnt + 4'd1;
                        if (conf_done) st_nxt = IDLE;
                    end else begin
                        st_nxt = HELD;
                    end
                end
                default: st_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        evt      = 1'b0;
        evt_code = cand;
        if (fecha) begin
            case (st)
                IDLE: begin
                    if (f_single && (DEB == 1)) begin
                        evt      = 1'b1;
                        evt_code = frame_code;
                    end
                end
                CONF:    evt = hit && conf_done;
                HELD:    evt = rep_fire;
                default: evt = 1'b0;
            endcase
        end
    end

    // An accepting Ack in the same cycle frees the slot for the new event.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Tecla   <= 4'h0;
            Valida  <= 1'b0;
            Estouro <= 1'b0;
        end else if (evt) begin
            if (!Valida || Ack) begin
                Tecla  <= evt_code;
                Valida <= 1'b1;
            end else begin
                Estouro <= 1'b1;
            end
        end else if (Valida && Ack) begin
            Valida <= 1'b0;
        end
    end

endmodule

// File: tb/tb_leitor_teclado.sv
// Bench for leitor_teclado: directed scenarios then randomized key frames, checked every cycle against a frame-level model.
module tb_leitor_teclado;

    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int REP = 2;
    localparam int FR  = 4 * DIV;

    localparam int S_IDLE = 0;
    localparam int S_CONF = 1;
    localparam int S_HELD = 2;
    localparam int S_REL  = 3;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Ack = 1'b0;
    logic [3:0] Lin;
    logic [3:0] Col, Tecla;
    logic       Valida, Estouro;

    logic [15:0] pressed = '0;
    int n_vec = 0;
    int n_err = 0;

    int         fcyc;
    int         m_st, m_cnt, m_rep;
    logic [3:0] m_cand, m_tecla;
    logic       m_valida, m_estouro;
    bit         ack_rand = 1'b0;

    leitor_teclado #(.DIV(DIV), .DEB(DEB), .REP(REP)) dut (
        .Clk(Clk), .Rst(Rst), .Lin(Lin), .Col(Col),
        .Tecla(Tecla), .Valida(Valida), .Ack(Ack), .Estouro(Estouro)
    );

    always #5 Clk = ~Clk;

    // Physical key matrix: a pressed key {c,r} pulls row r low while column c is strobed.
    always_comb begin
        Lin = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && (Col[c] == 1'b0)) Lin[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_cnt = 0; m_rep = 0; m_cand = 4'h0;
        m_tecla = 4'h0; m_valida = 1'b0; m_estouro = 1'b0;
        fcyc = 0;
    endtask

    // Frame-level debounce rules applied to the set of keys held during the frame.
    task automatic model_frame(output bit evt, output logic [3:0] code);
        int n, k;
        n = $countones(pressed);
        k = 0;
        for (int i = 0; i < 16; i++) if (pressed[i]) k = i;
        evt  = 1'b0;
        code = m_cand;
        case (m_st)
            S_IDLE: if (n == 1) begin
                m_cand = 4'(k); m_cnt = 1; code = 4'(k);
                if (DEB == 1) begin evt = 1'b1; m_st = S_HELD; m_rep = 0; end
                else m_st = S_CONF;
            end
            S_CONF: if (n == 1 && 4'(k) == m_cand) begin
                m_cnt++;
                if (m_cnt == DEB) begin evt = 1'b1; m_st = S_HELD; m_rep = 0; end
            end else if (n == 1) begin
                m_cand = 4'(k); m_cnt = 1;
            end else m_st = S_IDLE;
            S_HELD: if (n == 0) begin
                m_cnt = 1;
                m_st  = (DEB == 1) ? S_IDLE : S_REL;
            end else begin
`ifdef LEITOR_REPETE_EN
                if (n == 1 && 4'(k) == m_cand) begin
                    m_rep++;
                    if (m_rep == REP) begin evt = 1'b1; m_rep = 0; end
                end else m_rep = 0;
`endif
            end
            default: if (n == 0) begin
                m_cnt++;
                if (m_cnt == DEB) m_st = S_IDLE;
            end else begin
                m_st = S_HELD; m_rep = 0;
            end
        endcase
    endtask

    task automatic step();
        bit evt;
        logic [3:0] code;
        if (ack_rand) Ack = 1'($urandom_range(0, 1));
        chk("col", Col, ~(4'b0001 << ((fcyc / DIV) % 4)));
        chk("valida", {3'b0, Valida}, {3'b0, m_valida});
        chk("tecla", Tecla, m_tecla);
        chk("estouro", {3'b0, Estouro}, {3'b0, m_estouro});
        evt  = 1'b0;
        code = 4'h0;
        if (fcyc == FR - 1) model_frame(evt, code);
        if (evt) begin
            if (!m_valida || Ack) begin m_tecla = code; m_valida = 1'b1; end
            else m_estouro = 1'b1;
        end else if (m_valida && Ack) begin
            m_valida = 1'b0;
        end
        @(posedge Clk);
        #1;
        fcyc = (fcyc + 1) % FR;
    endtask

    task automatic frames(input logic [15:0] m, input int n);
        pressed = m;
        repeat (n * FR) step();
    endtask

    task automatic ack_pulse();
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        repeat (FR - 1) step();
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] m;
        do_reset();
        Ack = 1'b1;
        // Idle scan.
        frames(16'h0000, 5);
        // Single key col1,row2 held 6 frames.
        frames(16'h0001 << 6, 6);
        frames(16'h0000, 3);
        // Interrupted press restarts the count.
        frames(16'h0001 << 6, 2);
        frames(16'h0000, 1);
        frames(16'h0001 << 6, 3);
        frames(16'h0000, 3);
        // Two keys in different columns, then one released.
        frames((16'h0001 << 6) | (16'h0001 << 9), 5);
        frames(16'h0001 << 6, 3);
        frames(16'h0000, 3);
        // Overflow with no acknowledge.
        Ack = 1'b0;
        frames(16'h0001 << 3, 3);
        frames(16'h0000, 3);
        frames(16'h0001 << 12, 3);
        ack_pulse();
        frames(16'h0000, 3);
        // Reset in the middle of confirmation while the key stays held.
        Ack = 1'b1;
        frames(16'h0001 << 5, 2);
        do_reset();
        frames(16'h0001 << 5, 3);
        frames(16'h0000, 3);
        // Randomized key activity and acknowledge.
        do_reset();
        ack_rand = 1'b1;
        repeat (40) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: m = 16'h0000;
                9:          m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default:    m = 16'h0001 << $urandom_range(0, 15);
            endcase
            frames(m, $urandom_range(1, 5));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
